// File: rtl/grf_wb_arbiter_if.sv
// rtl/grf_wb_arbiter_if.sv - request/response bundle between write sources and the register-file write arbiter
interface grf_wb_arbiter_if;
  logic        w_valid;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [31:0] w_pc;
  logic        m_valid;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [31:0] m_pc;
  logic        m_ready;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] pending;
  logic [2:0]  fifo_cnt;

  modport master (
    output w_valid, w_a3, w_wd, w_pc,
    output m_valid, m_a3, m_wd, m_pc,
    input  m_ready, grf_we, grf_a3, grf_wd, grf_pc, pending, fifo_cnt
  );

  modport slave (
    input  w_valid, w_a3, w_wd, w_pc,
    input  m_valid, m_a3, m_wd, m_pc,
    output m_ready, grf_we, grf_a3, grf_wd, grf_pc, pending, fifo_cnt
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - W-stage / multi-cycle register write arbiter with 4-entry queue (optional trace: WB_DISPLAY_EN)
module grf_wb_arbiter (
  input logic              clk,
  input logic              reset,
  grf_wb_arbiter_if.slave  bus
);

  logic [4:0]  a3_q [4];
  logic [31:0] wd_q [4];
  logic [31:0] pc_q [4];
  logic [3:0]  vld_q;
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  cnt;

  logic        w_sel;
  logic        push;
  logic        pop;
  logic [4:0]  sel_a3;
  logic [31:0] sel_wd;
  logic [31:0] sel_pc;
  logic [31:0] pend;

  logic        grf_we_q;
  logic [4:0]  grf_a3_q;
  logic [31:0] grf_wd_q;
  logic [31:0] grf_pc_q;

  // Ready depends only on registered occupancy so the multi-cycle unit never sees a combinational path from W traffic.
  assign bus.m_ready  = (cnt != 3'd4);
  assign bus.fifo_cnt = cnt;
  assign bus.pending  = pend;
  assign bus.grf_we   = grf_we_q;
  assign bus.grf_a3   = grf_a3_q;
  assign bus.grf_wd   = grf_wd_q;
  assign bus.grf_pc   = grf_pc_q;

  // Write-port selection: W wins unconditionally; a $0 W request is dropped and lets the queue drain.
  always_comb begin
    w_sel  = bus.w_valid && (bus.w_a3 != 5'd0);
    push   = bus.m_valid && bus.m_ready && (bus.m_a3 != 5'd0);
    pop    = !w_sel && (cnt != 3'd0);
    sel_a3 = w_sel ? bus.w_a3 : a3_q[rd_ptr];
    sel_wd = w_sel ? bus.w_wd : wd_q[rd_ptr];
    sel_pc = w_sel ? bus.w_pc : pc_q[rd_ptr];
  end

  // Pending mask comes from queued entries only; $0 is never queued but is masked anyway.
  always_comb begin
    pend = '0;
    for (int i = 0; i < 4; i++) begin
      if (vld_q[i]) pend[a3_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  // Queue storage and pointers; pop uses registered occupancy so a push into an empty queue waits a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      cnt    <= 3'd0;
      vld_q  <= 4'd0;
    end else begin
      if (push) begin
        a3_q[wr_ptr]  <= bus.m_a3;
        wd_q[wr_ptr]  <= bus.m_wd;
        pc_q[wr_ptr]  <= bus.m_pc;
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 2'd1;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 2'd1;
      end
      cnt <= cnt + {2'd0, push} - {2'd0, pop};
    end
  end

  // Registered write port; address/data hold their last values while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we_q <= 1'b0;
      grf_a3_q <= 5'd0;
      grf_wd_q <= 32'd0;
      grf_pc_q <= 32'd0;
    end else begin
      grf_we_q <= w_sel || pop;
      if (w_sel || pop) begin
        grf_a3_q <= sel_a3;
        grf_wd_q <= sel_wd;
        grf_pc_q <= sel_pc;
      end
    end
  end

`ifdef WB_DISPLAY_EN
  // Commit trace of every register-file write as it is registered.
  always_ff @(posedge clk) begin
    if (!reset && (w_sel || pop)) begin
      $display("@%h: $%0d <= %h", sel_pc, sel_a3, sel_wd);
    end
  end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed scoreboard bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_fail;

  logic [68:0] mq [$];
  logic [68:0] sb [$];
  logic [68:0] last_wr;

  grf_wb_arbiter_if bus ();

  grf_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i][68:64]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic post_checks();
    logic [68:0] e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("grf_we", {31'd0, bus.grf_we}, 32'd1);
      check("grf_a3", {27'd0, bus.grf_a3}, {27'd0, e[68:64]});
      check("grf_wd", bus.grf_wd, e[63:32]);
      check("grf_pc", bus.grf_pc, e[31:0]);
      last_wr = e;
    end else begin
      check("grf_we_idle", {31'd0, bus.grf_we}, 32'd0);
      check("grf_a3_hold", {27'd0, bus.grf_a3}, {27'd0, last_wr[68:64]});
      check("grf_wd_hold", bus.grf_wd, last_wr[63:32]);
    end
    check("fifo_cnt", {29'd0, bus.fifo_cnt}, mq.size());
    check("pending", bus.pending, model_pending());
  endtask

  task automatic cycle(input logic wv, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] wp,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic [31:0] mp);
    logic rdy;
    bus.w_valid = wv; bus.w_a3 = wa; bus.w_wd = wd; bus.w_pc = wp;
    bus.m_valid = mv; bus.m_a3 = ma; bus.m_wd = md; bus.m_pc = mp;
    #1;
    rdy = (mq.size() != 4);
    check("m_ready", {31'd0, bus.m_ready}, {31'd0, rdy});
    if (wv && wa != 5'd0) sb.push_back({wa, wd, wp});
    else if (mq.size() != 0) sb.push_back(mq.pop_front());
    if (mv && rdy && ma != 5'd0) mq.push_back({ma, md, mp});
    @(posedge clk);
    #1;
    post_checks();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.w_valid = 1'b0; bus.w_a3 = '0; bus.w_wd = '0; bus.w_pc = '0;
    bus.m_valid = 1'b0; bus.m_a3 = '0; bus.m_wd = '0; bus.m_pc = '0;
    @(posedge clk);
    #1;
    mq.delete();
    sb.delete();
    last_wr = '0;
    reset = 1'b0;
    check("rst_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
    check("rst_pending", bus.pending, 32'd0);
    check("rst_we", {31'd0, bus.grf_we}, 32'd0);
    check("rst_a3", {27'd0, bus.grf_a3}, 32'd0);
    check("rst_wd", bus.grf_wd, 32'd0);
    check("rst_pc", bus.grf_pc, 32'd0);
    check("rst_m_ready", {31'd0, bus.m_ready}, 32'd1);
  endtask

  initial begin
    n_pass = 0;
    n_fail = 0;
    last_wr = '0;

    // Reset state
    do_reset();
    do_reset();

    // Basic W write
    cycle(1, 5'd5, 32'h12345678, 32'h3000, 0, 5'd0, 0, 0);
    check("basic_a3", {27'd0, bus.grf_a3}, 32'd5);
    check("basic_wd", bus.grf_wd, 32'h12345678);
    check("basic_pc", bus.grf_pc, 32'h3000);
    cycle(0, 5'd0, 0, 0, 0, 5'd0, 0, 0);

    // Fill to full under continuous W traffic to reg 9
    for (int i = 1; i <= 4; i++)
      cycle(1, 5'd9, 32'h9000 + i, 32'h3100 + 4 * i, 1, i[4:0], 32'hA000 + i, 32'h4000 + 4 * i);
    check("full_cnt", {29'd0, bus.fifo_cnt}, 32'd4);
    check("full_pending", bus.pending, 32'h1E);
    check("full_ready", {31'd0, bus.m_ready}, 32'd0);
    cycle(1, 5'd9, 32'h9005, 32'h3114, 1, 5'd5, 32'hA005, 32'h4014);

    // Drain in order; a $0 W request must not block the pop
    cycle(0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    check("drain_first", {27'd0, bus.grf_a3}, 32'd1);
    cycle(1, 5'd0, 32'hDEAD, 32'hBEEF, 0, 5'd0, 0, 0);
    check("drain_w0", {27'd0, bus.grf_a3}, 32'd2);
    cycle(0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    cycle(0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    check("drain_last", {27'd0, bus.grf_a3}, 32'd4);
    cycle(0, 5'd0, 0, 0, 0, 5'd0, 0, 0);

    // Push into empty does not pop same cycle; then simultaneous push/pop at cnt=2
    cycle(1, 5'd9, 32'h1, 32'h3200, 1, 5'd10, 32'hB010, 32'h5000);
    cycle(1, 5'd9, 32'h2, 32'h3204, 1, 5'd11, 32'hB011, 32'h5004);
    check("two_cnt", {29'd0, bus.fifo_cnt}, 32'd2);
    cycle(0, 5'd0, 0, 0, 1, 5'd7, 32'hB007, 32'h5008);
    check("pushpop_cnt", {29'd0, bus.fifo_cnt}, 32'd2);
    check("pushpop_a3", {27'd0, bus.grf_a3}, 32'd10);
    cycle(1, 5'd9, 32'h3, 32'h3208, 1, 5'd0, 32'hB000, 32'h500C);
    check("zero_cnt", {29'd0, bus.fifo_cnt}, 32'd2);
    check("zero_pending", bus.pending, 32'h0880);

    // Reach cnt=3, then reset mid-operation
    cycle(1, 5'd9, 32'h4, 32'h320C, 1, 5'd12, 32'hB012, 32'h5010);
    check("three_cnt", {29'd0, bus.fifo_cnt}, 32'd3);
    do_reset();

    // $0 handshake on empty queue: consumed, no write
    cycle(0, 5'd0, 0, 0, 1, 5'd0, 32'hC000, 32'h6000);
    check("zero_empty_we", {31'd0, bus.grf_we}, 32'd0);
    check("zero_empty_cnt", {29'd0, bus.fifo_cnt}, 32'd0);

    // Pointer wrap after reset: push/pop across index 3 -> 0
    for (int i = 0; i < 6; i++)
      cycle(i[0], 5'd20, 32'h7000 + i, 32'h7100 + i, 1, 5'(i + 13), 32'hD000 + i, 32'h8000 + i);
    for (int i = 0; i < 5; i++)
      cycle(0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    check("final_cnt", {29'd0, bus.fifo_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
